// File: rtl/byte_subtractor_serial_pkg.sv
// Shared definitions for the bit-serial subtractor: default width,
// FSM state encoding and the sizing rule for the bit counter.
package byte_subtractor_serial_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must hold the value WIDTH itself so it never wraps mid-operation.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

    localparam int CNT_W_DEFAULT = cnt_width(WIDTH_DEFAULT);

endpackage

// File: rtl/byte_subtractor_serial_full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, bout set when a borrow is needed.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/byte_subtractor_serial.sv
// Bit-serial subtractor. A start in IDLE captures the operands, then one
// bit per clock is produced LSB first through a single full_subtractor
// cell. After WIDTH bits the result is published on D/bout and done
// pulses for one cycle.
module byte_subtractor_serial
    import byte_subtractor_serial_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             bout
);

    localparam int             CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [WIDTH-1:0] res_reg, res_next;
    logic [WIDTH-1:0] d_reg, d_next;
    logic             borrow_reg, borrow_next;
    logic             bout_reg, bout_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    logic             bit_d;
    logic             bit_bout;
    logic [WIDTH-1:0] res_shifted;

    // The operand registers shift right each bit, so bit 0 is always the
    // bit currently being processed.
    full_subtractor u_cell (
        .a    (a_reg[0]),
        .b    (b_reg[0]),
        .bin  (borrow_reg),
        .d    (bit_d),
        .bout (bit_bout)
    );

    // Result accumulates from the MSB end: after WIDTH shifts the first
    // computed bit has reached position 0.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_res_shift
            if (gi == WIDTH - 1) begin : g_top
                assign res_shifted[gi] = bit_d;
            end else begin : g_low
                assign res_shifted[gi] = res_reg[gi+1];
            end
        end
    endgenerate

    // State and datapath registers; async reset clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            res_reg    <= '0;
            d_reg      <= '0;
            borrow_reg <= 1'b0;
            bout_reg   <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            res_reg    <= res_next;
            d_reg      <= d_next;
            borrow_reg <= borrow_next;
            bout_reg   <= bout_next;
            cnt_reg    <= cnt_next;
        end
    end

    // Next-state and datapath updates; everything holds unless a state acts on it.
    always_comb begin
        state_next  = state_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        res_next    = res_reg;
        d_next      = d_reg;
        borrow_next = borrow_reg;
        bout_next   = bout_reg;
        cnt_next    = cnt_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    a_next      = A;
                    b_next      = B;
                    borrow_next = bin;
                    res_next    = '0;
                    cnt_next    = '0;
                    state_next  = SUB;
                end
            end
            SUB: begin
                a_next      = a_reg >> 1;
                b_next      = b_reg >> 1;
                borrow_next = bit_bout;
                res_next    = res_shifted;
                cnt_next    = cnt_reg + CNT_W'(1);
                if (cnt_reg == LAST_BIT) begin
                    d_next     = res_shifted;
                    bout_next  = bit_bout;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state_reg == SUB) || (state_reg == DONE);
    assign done = (state_reg == DONE);
    assign D    = d_reg;
    assign bout = bout_reg;

endmodule

// File: tb/tb_byte_subtractor_serial.sv
// Bench for byte_subtractor_serial: an arithmetic reference model checked
// every cycle, plus directed operations with literal expected results.
module tb_byte_subtractor_serial;

    localparam int WIDTH = 8;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] A     = '0;
    logic [WIDTH-1:0] B     = '0;
    logic             bin   = 1'b0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] D;
    logic             bout;

    int checks     = 0;
    int errors     = 0;
    int cyc        = 0;
    int done_count = 0;
    int last_done  = -1;
    bit b2b_mode   = 1'b0;

    always #5 clk = ~clk;

    byte_subtractor_serial #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .D     (D),
        .bout  (bout)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    always @(posedge clk) cyc++;

    // Reference model: an accepted request yields A-B-bin after WIDTH+1 busy
    // cycles, the last of which is the done cycle.
    int               m_left = 0;
    logic [WIDTH:0]   m_full = '0;
    logic [WIDTH-1:0] m_D    = '0;
    logic             m_bout = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0;
            m_D    = '0;
            m_bout = 1'b0;
        end else if (m_left == 0) begin
            if (start) begin
                m_full = {1'b0, A} - {1'b0, B} - {{WIDTH{1'b0}}, bin};
                m_left = WIDTH + 1;
            end
        end else begin
            m_left--;
            if (m_left == 1) begin
                m_D    = m_full[WIDTH-1:0];
                m_bout = m_full[WIDTH];
            end
        end
    end

    // Per-cycle comparison against the model, plus done spacing when start is held.
    always @(negedge clk) begin
        chk("busy", busy, (m_left > 0));
        chk("done", done, (m_left == 1));
        chk("D", D, m_D);
        chk("bout", bout, m_bout);
        if (!b2b_mode) last_done = -1;
        if (done) begin
            done_count++;
            $display("done: D=0x%02h bout=%0d cycle=%0d", D, bout, cyc);
            if (b2b_mode) begin
                if (last_done >= 0) chk("b2b_spacing", cyc - last_done, 10);
                last_done = cyc;
            end
        end
    end

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                          input logic [7:0] exp_d, input logic exp_bo, input string name);
        int n;
        n = 0;
        @(posedge clk); #1;
        A = a; B = b; bin = c; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        A = 8'($urandom); B = 8'($urandom); bin = 1'($urandom);
        for (int k = 1; k <= 20 && n == 0; k++) begin
            @(negedge clk);
            if (done) n = k;
        end
        chk({name, "_latency"}, n, 9);
        chk({name, "_D"}, D, exp_d);
        chk({name, "_bout"}, bout, exp_bo);
        chk({name, "_model_D"}, m_D, exp_d);
        chk({name, "_model_bout"}, m_bout, exp_bo);
        @(posedge clk);
    endtask

    initial begin
        int dc0;

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_D", D, 0);
        chk("rst_bout", bout, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed operations
        run_op(8'h01, 8'h01, 1'b0, 8'h00, 1'b0, "op_1m1");
        run_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, "op_0m1");
        run_op(8'hAB, 8'h01, 1'b0, 8'hAA, 1'b0, "op_ABm1");
        run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "op_FFmFFb");
        run_op(8'h0F, 8'h07, 1'b1, 8'h07, 1'b0, "op_0Fm07b");

        // Start pulsed mid-operation is ignored
        @(posedge clk); #1;
        A = 8'h10; B = 8'h01; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dc0 = done_count;
        repeat (3) @(posedge clk);
        #1 A = 8'h55; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("ignore_done_count", done_count - dc0, 1);
        chk("ignore_D", D, 8'h0F);
        chk("ignore_bout", bout, 0);
        chk("ignore_idle", busy, 0);

        // Reset mid-operation aborts with no done
        @(posedge clk); #1;
        A = 8'h20; B = 8'h01; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_D", D, 0);
        chk("abort_bout", bout, 0);
        dc0 = done_count;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("abort_no_done", done_count - dc0, 0);
        run_op(8'h03, 8'h01, 1'b0, 8'h02, 1'b0, "after_rst");

        // Back-to-back random operations with start held high
        @(posedge clk); #1;
        b2b_mode = 1'b1;
        dc0 = done_count;
        A = 8'($urandom); B = 8'($urandom); bin = 1'($urandom);
        start = 1'b1;
        for (int i = 0; i < 256; i++) begin
            @(posedge clk); #1;
            if (i == 255) begin
                start = 1'b0;
            end else begin
                A = 8'($urandom); B = 8'($urandom); bin = 1'($urandom);
            end
            repeat (9) @(posedge clk);
        end
        repeat (3) @(posedge clk);
        #1;
        b2b_mode = 1'b0;
        chk("b2b_done_count", done_count - dc0, 256);
        chk("b2b_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule
